dm_cache_ctrl: RTL

Controller FSM for the 512-block, direct-mapped, write-back, write-allocate cache. It sits between the CPU request port and the tag memory, data memory and next-level memory. It drives the tag memory's index, write-enable and write data, and consumes its combinational read port. It performs tag compare, hit service, dirty-line write-back and line refill.

---
 rtl/dm_cache_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/dm_cache_ctrl.sv
// Controller for a 512-line direct-mapped, write-back, write-allocate cache.
// Performs tag compare, hit service, dirty-line write-back and line refill.
module dm_cache_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cpu_valid,
    input  logic         cpu_rw,
    input  logic [31:0]  cpu_addr,
    input  logic [31:0]  cpu_wdata,
    output logic [31:0]  cpu_rdata,
    output logic         cpu_ready,
    output logic [8:0]   tag_index,
    output logic         tag_we,
    output logic [19:0]  tag_wdata,
    input  logic [19:0]  tag_rdata,
    output logic [8:0]   data_index,
    output logic         data_we,
    output logic [255:0] data_wdata,
    input  logic [255:0] data_rdata,
    output logic         mem_valid,
    output logic         mem_rw,
    output logic [31:0]  mem_addr,
    output logic [255:0] mem_wdata,
    input  logic [255:0] mem_rdata,
    input  logic         mem_ready,
    output logic [1:0]   fsm_state
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        COMPARE_TAG = 2'd1,
        WRITE_BACK  = 2'd2,
        ALLOCATE    = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] req_addr;
    logic        req_rw;
    logic [31:0] req_wdata;
    logic        hit;
    logic [7:0]  word_base;

    assign fsm_state = state;
    assign hit       = tag_rdata[19] && (tag_rdata[17:0] == req_addr[31:14]);
    assign word_base = {req_addr[4:2], 5'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_addr  <= '0;
            req_rw    <= 1'b0;
            req_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_valid) begin
                        req_addr  <= cpu_addr;
                        req_rw    <= cpu_rw;
                        req_wdata <= cpu_wdata;
                        state     <= COMPARE_TAG;
                    end
                end
                COMPARE_TAG: begin
                    if (hit)
                        state <= IDLE;
                    else if (tag_rdata[19] && tag_rdata[18])
                        state <= WRITE_BACK;
                    else
                        state <= ALLOCATE;
                end
                WRITE_BACK: if (mem_ready) state <= ALLOCATE;
                ALLOCATE:   if (mem_ready) state <= COMPARE_TAG;
                default:    state <= IDLE;
            endcase
        end
    end

    // Memory ports see the incoming address while idle so the tag read is
    // already valid in the first COMPARE_TAG cycle.
    always_comb begin
        tag_index  = (state == IDLE) ? cpu_addr[13:5] : req_addr[13:5];
        data_index = tag_index;
        cpu_rdata  = '0;
        cpu_ready  = 1'b0;
        tag_we     = 1'b0;
        tag_wdata  = '0;
        data_we    = 1'b0;
        data_wdata = '0;
        mem_valid  = 1'b0;
        mem_rw     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            COMPARE_TAG: begin
                if (hit) begin
                    cpu_ready = 1'b1;
                    if (req_rw) begin
                        data_we    = 1'b1;
                        data_wdata = data_rdata;
                        data_wdata[word_base +: 32] = req_wdata;
                        tag_we     = 1'b1;
                        tag_wdata  = {1'b1, 1'b1, req_addr[31:14]};
                    end else begin
                        cpu_rdata = data_rdata[word_base +: 32];
                    end
                end
            end
            WRITE_BACK: begin
                mem_valid = 1'b1;
                mem_rw    = 1'b1;
                mem_addr  = {tag_rdata[17:0], req_addr[13:5], 5'b0};
                mem_wdata = data_rdata;
            end
            ALLOCATE: begin
                mem_valid = 1'b1;
                mem_addr  = {req_addr[31:5], 5'b0};
                if (mem_ready) begin
                    data_we    = 1'b1;
                    data_wdata = mem_rdata;
                    tag_we     = 1'b1;
                    tag_wdata  = {1'b1, 1'b0, req_addr[31:14]};
                end
            end
            default: ;
        endcase
    end

endmodule
